// File: rtl/rns2bin_crt_if.sv
// Handshake bundle for the RNS-to-binary converter: residue word in, signed binary result out.
// Both sides use valid/ready: a transfer happens on a rising edge where valid && ready; valid
// holds its data stable until then, and neither ready nor valid depends combinationally on the other.
interface rns2bin_crt_if #(
   parameter int OUT_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       r_mod_1;
   logic [2:0]       r_mod_2;
   logic [2:0]       r_mod_3;
   logic [2:0]       r_mod_4;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] n_out;
   logic             err;

   modport master (
      output in_valid, r_mod_1, r_mod_2, r_mod_3, r_mod_4, out_ready,
      input  in_ready, out_valid, n_out, err
   );

   modport slave (
      input  in_valid, r_mod_1, r_mod_2, r_mod_3, r_mod_4, out_ready,
      output in_ready, out_valid, n_out, err
   );
endinterface

// File: rtl/rns2bin_crt_seq.sv
// Sequential CRT converter, moduli {3,5,7,8} (M=840) -> signed value in -420..419.
// Optional residue range check enabled by defining RNS_RESIDUE_CHECK_EN.
module rns2bin_crt_seq #(
   parameter int OUT_W = 32,
   parameter int ACC_W = 12
) (
   input  logic                clk,
   input  logic                reset,
   rns2bin_crt_if.slave        bus,
   output logic [1:0]          dbg_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, FIX = 2'd2, HOLD = 2'd3} state_t;

   localparam logic [ACC_W-1:0] W1 = ACC_W'(280);
   localparam logic [ACC_W-1:0] W2 = ACC_W'(336);
   localparam logic [ACC_W-1:0] W3 = ACC_W'(120);
   localparam logic [ACC_W-1:0] W4 = ACC_W'(105);

   state_t           state, state_next;
   logic [2:0]       r_q [4];
   logic [ACC_W-1:0] acc;
   logic [1:0]       idx;
   logic [OUT_W-1:0] n_q;
   logic             res_bad;
   logic [2:0]       r_sel;
   logic [ACC_W-1:0] w_sel;
   logic [ACC_W-1:0] term;
   logic [ACC_W-1:0] x_red;
   logic signed [ACC_W:0] x_signed;

`ifdef RNS_RESIDUE_CHECK_EN
   logic err_q;
   assign res_bad = (bus.r_mod_1 >= 3'd3) | (bus.r_mod_2 >= 3'd5) | (bus.r_mod_3 >= 3'd7);
   assign bus.err = err_q;
`else
   assign res_bad = 1'b0;
   assign bus.err = 1'b0;
`endif

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == HOLD);
   assign bus.n_out     = n_q;
   assign dbg_state     = state;

   // One residue term per ACC cycle, selected by idx.
   always_comb begin
      r_sel = r_q[0];
      w_sel = W1;
      case (idx)
         2'd0: begin r_sel = r_q[0]; w_sel = W1; end
         2'd1: begin r_sel = r_q[1]; w_sel = W2; end
         2'd2: begin r_sel = r_q[2]; w_sel = W3; end
         default: begin r_sel = r_q[3]; w_sel = W4; end
      endcase
      term = ACC_W'(r_sel) * w_sel;
   end

   // Raw sum is below 4*840, so one of three fixed subtractions lands it in 0..839.
   always_comb begin
      x_red = acc;
      if (acc >= ACC_W'(2520))      x_red = acc - ACC_W'(2520);
      else if (acc >= ACC_W'(1680)) x_red = acc - ACC_W'(1680);
      else if (acc >= ACC_W'(840))  x_red = acc - ACC_W'(840);
      x_signed = $signed({1'b0, x_red});
      if (x_red >= ACC_W'(420)) x_signed = $signed({1'b0, x_red}) - $signed((ACC_W+1)'(840));
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (bus.in_valid) state_next = res_bad ? HOLD : ACC;
         ACC:  if (idx == 2'd3)  state_next = FIX;
         FIX:  state_next = HOLD;
         HOLD: if (bus.out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) r_q[i] <= 3'd0;
         acc <= '0;
         idx <= 2'd0;
         n_q <= '0;
`ifdef RNS_RESIDUE_CHECK_EN
         err_q <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               r_q[0] <= bus.r_mod_1;
               r_q[1] <= bus.r_mod_2;
               r_q[2] <= bus.r_mod_3;
               r_q[3] <= bus.r_mod_4;
               acc    <= '0;
               idx    <= 2'd0;
`ifdef RNS_RESIDUE_CHECK_EN
               err_q  <= res_bad;
               if (res_bad) n_q <= '0;
`endif
            end
            ACC: begin
               acc <= acc + term;
               idx <= idx + 2'd1;
            end
            FIX: n_q <= OUT_W'(x_signed);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rns2bin_crt_seq.sv
// Directed bench for rns2bin_crt_seq: hand-computed vectors, boundaries, a full-range sweep,
// backpressure and mid-conversion reset.
module tb_rns2bin_crt_seq;
  localparam int OUT_W = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;
  int         total = 0;
  int         bad = 0;
  logic [32:0] exp_q[$];

  rns2bin_crt_if #(.OUT_W(OUT_W)) bus();

  rns2bin_crt_seq #(.OUT_W(OUT_W), .ACC_W(12)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // called at a negedge; returns just after the accept edge
  task automatic drive_word(input int a, input int b, input int c, input int d);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.r_mod_1 = 3'(a);
    bus.r_mod_2 = 3'(b);
    bus.r_mod_3 = 3'(c);
    bus.r_mod_4 = 3'(d);
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("accept_wait", 64'(waited < 50), 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input int exp_lat);
    int lat = 0;
    logic [32:0] e;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!bus.out_valid && lat < 20);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_n"}, 64'(bus.n_out), 64'(e[31:0]));
      check({tag, "_err"}, 64'(bus.err), 64'(e[32]));
    end else begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
    end
    if (bus.out_ready) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_drop"}, 64'(bus.out_valid), 64'd0);
    end
  endtask

  task automatic run_word(input string tag, input int a, input int b, input int c, input int d,
                          input int exp_n, input logic exp_err, input int exp_lat);
    @(negedge clk);
    exp_q.push_back({exp_err, 32'(exp_n)});
    drive_word(a, b, c, d);
    collect(tag, exp_lat);
  endtask

  initial begin
    int x;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.r_mod_1 = 3'd0;
    bus.r_mod_2 = 3'd0;
    bus.r_mod_3 = 3'd0;
    bus.r_mod_4 = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_n_out", 64'(bus.n_out), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    reset = 1'b0;

    run_word("zero", 0, 0, 0, 0, 0, 1'b0, 5);
    run_word("minus1", 2, 4, 6, 7, -1, 1'b0, 5);
    run_word("one", 1, 1, 1, 1, 1, 1'b0, 5);
    run_word("min", 0, 0, 0, 4, -420, 1'b0, 5);
    run_word("max", 2, 4, 6, 3, 419, 1'b0, 5);
    run_word("p100", 1, 0, 2, 4, 100, 1'b0, 5);
    run_word("m100", 2, 0, 5, 4, -100, 1'b0, 5);
    run_word("m419", 1, 1, 1, 5, -419, 1'b0, 5);

    // backpressure: result must hold while a new word waits
    bus.out_ready = 1'b0;
    run_word("bp", 2, 4, 6, 7, -1, 1'b0, 5);
    bus.in_valid = 1'b1;
    bus.r_mod_1 = 3'd1;
    bus.r_mod_2 = 3'd1;
    bus.r_mod_3 = 3'd1;
    bus.r_mod_4 = 3'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(bus.out_valid), 64'd1);
      check("bp_n", 64'(bus.n_out), 64'hFFFF_FFFF);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_valid", 64'(bus.out_valid), 64'd0);
    check("bp_release_ready", 64'(bus.in_ready), 64'd1);
    exp_q.push_back({1'b0, 32'd1});
    drive_word(1, 1, 1, 1);
    collect("bp_next", 5);

    // reset in the third ACC cycle drops the word
    @(negedge clk);
    drive_word(2, 4, 6, 7);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("mid_state_acc", 64'(dbg_state), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_state", 64'(dbg_state), 64'd0);
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_ready", 64'(bus.in_ready), 64'd1);
    check("mid_rst_n", 64'(bus.n_out), 64'd0);
    run_word("after_rst", 1, 1, 1, 1, 1, 1'b0, 5);

`ifdef RNS_RESIDUE_CHECK_EN
    run_word("bad_r1", 3, 0, 0, 0, 0, 1'b1, 1);
    run_word("bad_r3", 0, 0, 7, 0, 0, 1'b1, 1);
    run_word("clean_after_bad", 1, 1, 1, 1, 1, 1'b0, 5);
`else
    run_word("nochk_r1", 3, 0, 0, 0, 0, 1'b0, 5);
`endif

    // full range: residues of n must convert back to n
    for (int n = -420; n <= 419; n++) begin
      x = (n + 840) % 840;
      run_word("sweep", x % 3, x % 5, x % 7, x % 8, n, 1'b0, 5);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
